fpu_prenorm_div_sqrt: RTL and testbench
=======================================

// Module: fpu_prenorm_div_sqrt
// PURPOSE
//  Operand front end of the div/sqrt datapath; the output normalizer/rounder is the other end.
//  - Unpacks two IEEE operands; classifies NaN/Inf/Zero/denormal.
//  - Normalizes denormal mantissas to 1.xxx and precomputes result sign and biased exponent.
//  - Delivers one registered operand bundle per op over a valid/ready handshake to the iteration core.
// PARAMETERS
//  C_EXP_W   8   exponent field width
//  C_MANT_W  23  fraction field width (hidden bit excluded)
// PORTS
//  Clk_CI       in   1           clock
//  Rst_RI       in   1           asynchronous reset, active-high
//  Valid_SI     in   1           operands/op valid
//  Ready_SO     out  1           block can accept
//  Kill_SI      in   1           synchronous abort of in-flight op
//  Div_start_SI in   1           op = divide (sampled with Valid_SI)
//  Sqrt_start_SI in  1           op = sqrt (B ignored)
//  Operand_a_DI in   1+EXP+MANT  IEEE operand A
//  Operand_b_DI in   1+EXP+MANT  IEEE operand B
//  RM_SI        in   C_DIV_RM    rounding mode, passed through
//  Valid_SO     out  1           bundle valid
//  Ready_SI     in   1           consumer accepts bundle
//  Mant_a_DO    out  MANT+1      normalized A mantissa 1.f (0 if zero/Inf/NaN)
//  Mant_b_DO    out  MANT+1      normalized B mantissa
//  Exp_res_DO   out  EXP+2       signed biased result exponent estimate
//  Sqrt_odd_SO  out  1           sqrt unbiased exponent odd: core pre-shifts Mant_a left 1
//  Sign_res_DO  out  1           div: sa^sb; sqrt: sa
//  Div_en_SO, Sqrt_en_SO  out 1  registered op type
//  NaN_a_SO,NaN_b_SO,Inf_a_SO,Inf_b_SO,Zero_a_SO,Zero_b_SO  out 1  class flags
//  RM_SO        out  C_DIV_RM    registered rounding mode
// BEHAVIOUR
//  - FSM IDLE/NORM/DONE. Reset: state IDLE; all outputs 0 except Ready_SO=1.
//  - IDLE: Ready_SO=1. Valid_SI&&(Div_start^Sqrt_start): capture operands/RM/op -> NORM.
//    Both or neither start bit set: ignore, stay IDLE.
//  - NORM (1 cycle): LZC, shift, exponent math; register bundle -> DONE.
//  - DONE: Valid_SO=1, bundle stable; on Ready_SI -> IDLE. Accept-to-Valid_SO latency 2.
//  - Ready_SO=0 outside IDLE; no new op accepted in the handover cycle.
//  - Kill_SI in any state: next state IDLE, Valid_SO=0 next cycle; wins over Valid_SI/Ready_SI.
//  - Classify: NaN = exp all ones, f!=0; Inf = exp all ones, f=0; Zero = exp 0, f=0; denormal = exp 0, f!=0.
//  - Exponent/mantissa:
//    - Normal: M={1,f}, E=exp.
//    - Denormal: lz = leading zeros of f (0..MANT-1); M=({f,1'b0}<<lz) with MSB=1; E=-lz, signed.
//  - Div: Exp_res=Ea-Eb+BIAS at EXP+2 bits signed; no saturation (the output normalizer handles OF/UF).
//  - Sqrt: U=Ea-BIAS; Sqrt_odd=U[0]; Exp_res=(U>>>1)+BIAS (arithmetic shift).
//  - Sqrt: B flags forced 0; Mant_b=0.
//  - Special classes: flags set, mantissa 0, Exp_res computed but don't-care.
//  - Rst_RI mid-op: op lost, immediate return to reset values.
// CONFIGURATION
//  FPU_PRENORM_DAZ_EN defined:
//   - Denormal inputs flushed to signed zero: Zero flag=1, mantissa 0.
//   - NORM skipped: IDLE->DONE, latency 1; LZC not instantiated.
//  Undefined: full denormal normalization as above.
// STRUCTURE
//  - Package fpu_defs_div_sqrt_tp: C_DIV_EXP, C_DIV_MANT, C_DIV_RM, C_DIV_BIAS, state enum typedef.
//  - Sub-module fpu_lzc_div_sqrt: combinational leading-zero count, MANT-bit input, all-zero flag.
// TESTING
//  1 div 6.0(0x40C00000)/1.5(0x3FC00000): Valid_SO at +2; Mant_a=0xC00000, Mant_b=0xC00000, Exp_res=129, Sign=0.
//  2 div A=0x00000001: Mant_a=0x800000, Exp_res=-22-Eb+127; with DAZ: Zero_a=1, Valid_SO at +1.
//  3 sqrt 0x41000000(8.0): U=3, Sqrt_odd=1, Exp_res=128; sqrt 4.0: Sqrt_odd=0, Exp_res=128.
//  4 div NaN/1.0, Inf/Inf, 0/0: NaN_a=1 / Inf_a=Inf_b=1 / Zero_a=Zero_b=1; Sign_res=sa^sb.
//  5 Ready_SI=0 for 5 cycles in DONE: bundle and Valid_SO stable, Ready_SO=0; Valid_SI ignored.
//  6 Kill_SI in NORM, and Rst_RI pulse in DONE: Valid_SO=0 next cycle, Ready_SO=1; next op correct.

Source files
------------

// File: rtl/fpu_defs_div_sqrt_tp.sv
// Shared widths, bias and FSM encoding for the div/sqrt operand front end.
package fpu_defs_div_sqrt_tp;

    localparam int C_DIV_EXP  = 8;
    localparam int C_DIV_MANT = 23;
    localparam int C_DIV_RM   = 3;
    localparam int C_DIV_BIAS = (1 << (C_DIV_EXP - 1)) - 1;

    typedef enum logic [1:0] {
        DIV_SQRT_IDLE = 2'd0,
        DIV_SQRT_NORM = 2'd1,
        DIV_SQRT_DONE = 2'd2
    } div_sqrt_state_e;

endpackage

// File: rtl/fpu_lzc_div_sqrt.sv
// Combinational leading-zero counter over a fraction field, with an all-zero flag.
module fpu_lzc_div_sqrt #(
    parameter int C_WIDTH = 23,
    parameter int C_CNT_W = $clog2(C_WIDTH)
) (
    input  logic [C_WIDTH-1:0] Data_DI,
    output logic [C_CNT_W-1:0] Cnt_DO,
    output logic               Zero_SO
);

    // NOTE: the default assignment ahead of the loop keeps this always_comb latch-free.
    always_comb begin
        Cnt_DO = '0;
        // Ascending scan: the highest set bit is assigned last and wins.
        for (int i = 0; i < C_WIDTH; i++) begin
            if (Data_DI[i]) begin
                Cnt_DO = C_CNT_W'(C_WIDTH - 1 - i);
            end
        end
    end

    assign Zero_SO = ~|Data_DI;

endmodule

// File: rtl/fpu_prenorm_div_sqrt.sv
// Div/sqrt operand front end: classify, normalize, precompute sign/exponent, hand over one bundle.
// Build option: FPU_PRENORM_DAZ_EN flushes denormals to zero and skips the NORM cycle.
module fpu_prenorm_div_sqrt
    import fpu_defs_div_sqrt_tp::*;
#(
    parameter int C_EXP_W  = C_DIV_EXP,
    parameter int C_MANT_W = C_DIV_MANT
) (
    input  logic                        Clk_CI,
    input  logic                        Rst_RI,
    input  logic                        Valid_SI,
    output logic                        Ready_SO,
    input  logic                        Kill_SI,
    input  logic                        Div_start_SI,
    input  logic                        Sqrt_start_SI,
    input  logic [C_EXP_W+C_MANT_W:0]   Operand_a_DI,
    input  logic [C_EXP_W+C_MANT_W:0]   Operand_b_DI,
    input  logic [C_DIV_RM-1:0]         RM_SI,
    output logic                        Valid_SO,
    input  logic                        Ready_SI,
    output logic [C_MANT_W:0]           Mant_a_DO,
    output logic [C_MANT_W:0]           Mant_b_DO,
    output logic [C_EXP_W+1:0]          Exp_res_DO,
    output logic                        Sqrt_odd_SO,
    output logic                        Sign_res_DO,
    output logic                        Div_en_SO,
    output logic                        Sqrt_en_SO,
    output logic                        NaN_a_SO,
    output logic                        NaN_b_SO,
    output logic                        Inf_a_SO,
    output logic                        Inf_b_SO,
    output logic                        Zero_a_SO,
    output logic                        Zero_b_SO,
    output logic [C_DIV_RM-1:0]         RM_SO
);

    localparam int OP_W      = 1 + C_EXP_W + C_MANT_W;
    localparam int EXP_RES_W = C_EXP_W + 2;
    localparam logic signed [EXP_RES_W-1:0] BIAS = EXP_RES_W'((1 << (C_EXP_W - 1)) - 1);

    localparam logic [1:0] IDLE = DIV_SQRT_IDLE;
    localparam logic [1:0] NORM = DIV_SQRT_NORM;
    localparam logic [1:0] DONE = DIV_SQRT_DONE;

    logic [1:0] state_q, state_d, after_accept;
    logic       accept, load_bundle, src_sqrt;

    logic [OP_W-1:0]                  src [2];
    logic [C_MANT_W:0]                mant [2];
    logic signed [EXP_RES_W-1:0]      expo [2];
    logic                             is_nan [2];
    logic                             is_inf [2];
    logic                             is_zero [2];

    assign accept = (state_q == IDLE) && Valid_SI && (Div_start_SI ^ Sqrt_start_SI) && !Kill_SI;

`ifdef FPU_PRENORM_DAZ_EN
    // Operands are consumed straight from the ports in the accept cycle.
    assign src[0]       = Operand_a_DI;
    assign src[1]       = Operand_b_DI;
    assign src_sqrt     = Sqrt_start_SI;
    assign load_bundle  = accept;
    assign after_accept = DONE;
`else
    logic [OP_W-1:0] op_a_q, op_b_q;

    assign src[0]       = op_a_q;
    assign src[1]       = op_b_q;
    assign src_sqrt     = Sqrt_en_SO;
    assign load_bundle  = (state_q == NORM) && !Kill_SI;
    assign after_accept = NORM;
`endif

    for (genvar k = 0; k < 2; k++) begin : g_opnd
        logic [C_EXP_W-1:0]  exp_f;
        logic [C_MANT_W-1:0] frac;
        logic                exp_ones, exp_zero, frac_zero;

        assign exp_f    = src[k][OP_W-2 -: C_EXP_W];
        assign frac     = src[k][C_MANT_W-1:0];
        assign exp_ones = &exp_f;
        assign exp_zero = ~|exp_f;

`ifdef FPU_PRENORM_DAZ_EN
        assign frac_zero  = ~|frac;
        assign is_zero[k] = exp_zero;
        assign mant[k]    = (exp_zero || exp_ones) ? '0 : {1'b1, frac};
        assign expo[k]    = exp_zero ? '0 : {2'b00, exp_f};
`else
        localparam int LZ_W = $clog2(C_MANT_W);
        logic [LZ_W-1:0]             lz;
        logic [C_MANT_W:0]           mant_l;
        logic signed [EXP_RES_W-1:0] expo_l;

        fpu_lzc_div_sqrt #(
            .C_WIDTH (C_MANT_W)
        ) i_lzc (
            .Data_DI (frac),
            .Cnt_DO  (lz),
            .Zero_SO (frac_zero)
        );

        // A denormal 0.f shifted by lz+1 becomes 1.x with unbiased-plus-bias exponent -lz.
        always_comb begin
            mant_l = {1'b1, frac};
            expo_l = {2'b00, exp_f};
            if (exp_ones) begin
                mant_l = '0;
            end else if (exp_zero) begin
                if (frac_zero) begin
                    mant_l = '0;
                end else begin
                    mant_l = {frac, 1'b0} << lz;
                    expo_l = -(EXP_RES_W'(lz));
                end
            end
        end

        assign is_zero[k] = exp_zero && frac_zero;
        assign mant[k]    = mant_l;
        assign expo[k]    = expo_l;
`endif
        assign is_nan[k] = exp_ones && !frac_zero;
        assign is_inf[k] = exp_ones && frac_zero;
    end

    logic signed [EXP_RES_W-1:0] div_exp, sqrt_u, sqrt_exp;
    logic                        sign_a, sign_b;

    assign div_exp  = expo[0] - expo[1] + BIAS;
    assign sqrt_u   = expo[0] - BIAS;
    assign sqrt_exp = (sqrt_u >>> 1) + BIAS;
    assign sign_a   = src[0][OP_W-1];
    assign sign_b   = src[1][OP_W-1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = after_accept;
            NORM:    state_d = DONE;
            DONE:    if (Ready_SI) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (Kill_SI) state_d = IDLE;
    end

    assign Ready_SO = (state_q == IDLE);
    assign Valid_SO = (state_q == DONE);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
`ifndef FPU_PRENORM_DAZ_EN
            op_a_q      <= '0;
            op_b_q      <= '0;
`endif
            Div_en_SO   <= 1'b0;
            Sqrt_en_SO  <= 1'b0;
            RM_SO       <= '0;
            Mant_a_DO   <= '0;
            Mant_b_DO   <= '0;
            Exp_res_DO  <= '0;
            Sqrt_odd_SO <= 1'b0;
            Sign_res_DO <= 1'b0;
            NaN_a_SO    <= 1'b0;
            NaN_b_SO    <= 1'b0;
            Inf_a_SO    <= 1'b0;
            Inf_b_SO    <= 1'b0;
            Zero_a_SO   <= 1'b0;
            Zero_b_SO   <= 1'b0;
        end else begin
            if (accept) begin
`ifndef FPU_PRENORM_DAZ_EN
                op_a_q     <= Operand_a_DI;
                op_b_q     <= Operand_b_DI;
`endif
                Div_en_SO  <= Div_start_SI;
                Sqrt_en_SO <= Sqrt_start_SI;
                RM_SO      <= RM_SI;
            end
            if (load_bundle) begin
                Mant_a_DO   <= mant[0];
                Mant_b_DO   <= src_sqrt ? '0 : mant[1];
                Exp_res_DO  <= src_sqrt ? sqrt_exp : div_exp;
                Sqrt_odd_SO <= src_sqrt && sqrt_u[0];
                Sign_res_DO <= src_sqrt ? sign_a : (sign_a ^ sign_b);
                NaN_a_SO    <= is_nan[0];
                Inf_a_SO    <= is_inf[0];
                Zero_a_SO   <= is_zero[0];
                NaN_b_SO    <= !src_sqrt && is_nan[1];
                Inf_b_SO    <= !src_sqrt && is_inf[1];
                Zero_b_SO   <= !src_sqrt && is_zero[1];
            end
        end
    end

endmodule

// File: tb/tb_fpu_prenorm_div_sqrt.sv
// Self-checking bench for fpu_prenorm_div_sqrt against an IEEE-level reference model.
module tb_fpu_prenorm_div_sqrt;
    import fpu_defs_div_sqrt_tp::*;

`ifdef FPU_PRENORM_DAZ_EN
    localparam bit DAZ     = 1'b1;
    localparam int EXP_LAT = 1;
`else
    localparam bit DAZ     = 1'b0;
    localparam int EXP_LAT = 2;
`endif

    logic        Clk_CI, Rst_RI, Valid_SI, Ready_SO, Kill_SI, Div_start_SI, Sqrt_start_SI;
    logic [31:0] Operand_a_DI, Operand_b_DI;
    logic [2:0]  RM_SI, RM_SO;
    logic        Valid_SO, Ready_SI;
    logic [23:0] Mant_a_DO, Mant_b_DO;
    logic [9:0]  Exp_res_DO;
    logic        Sqrt_odd_SO, Sign_res_DO, Div_en_SO, Sqrt_en_SO;
    logic        NaN_a_SO, NaN_b_SO, Inf_a_SO, Inf_b_SO, Zero_a_SO, Zero_b_SO;

    int total = 0;
    int bad   = 0;

    fpu_prenorm_div_sqrt dut (
        .Clk_CI(Clk_CI), .Rst_RI(Rst_RI), .Valid_SI(Valid_SI), .Ready_SO(Ready_SO),
        .Kill_SI(Kill_SI), .Div_start_SI(Div_start_SI), .Sqrt_start_SI(Sqrt_start_SI),
        .Operand_a_DI(Operand_a_DI), .Operand_b_DI(Operand_b_DI), .RM_SI(RM_SI),
        .Valid_SO(Valid_SO), .Ready_SI(Ready_SI), .Mant_a_DO(Mant_a_DO), .Mant_b_DO(Mant_b_DO),
        .Exp_res_DO(Exp_res_DO), .Sqrt_odd_SO(Sqrt_odd_SO), .Sign_res_DO(Sign_res_DO),
        .Div_en_SO(Div_en_SO), .Sqrt_en_SO(Sqrt_en_SO),
        .NaN_a_SO(NaN_a_SO), .NaN_b_SO(NaN_b_SO), .Inf_a_SO(Inf_a_SO), .Inf_b_SO(Inf_b_SO),
        .Zero_a_SO(Zero_a_SO), .Zero_b_SO(Zero_b_SO), .RM_SO(RM_SO)
    );

    initial Clk_CI = 1'b0;
    always #5 Clk_CI = ~Clk_CI;

    typedef struct {
        logic [23:0] ma, mb;
        logic [9:0]  er;
        logic        odd, sign, special;
        logic [5:0]  flags;   // {nan_a, nan_b, inf_a, inf_b, zero_a, zero_b}
    } expect_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value-level view of one operand: mantissa scaled so 1.0 == 2^23, biased exponent.
    function automatic void unpack_op(input logic [31:0] x, output logic nan, output logic inf,
                                      output logic zero, output int m, output int e);
        int ex = int'(x[30:23]);
        int f  = int'(x[22:0]);
        nan = 1'b0; inf = 1'b0; zero = 1'b0; m = 0; e = ex;
        if (ex == 255) begin
            nan = (f != 0);
            inf = (f == 0);
        end else if (ex == 0) begin
            if (f == 0 || DAZ) begin
                zero = 1'b1;
            end else begin
                m = f;
                e = 1;
                while (m < (1 << 23)) begin
                    m = m * 2;
                    e = e - 1;
                end
            end
        end else begin
            m = (1 << 23) + f;
        end
    endfunction

    function automatic expect_t model(input logic [31:0] a, input logic [31:0] b, input bit sq);
        expect_t r;
        logic na, nb, ia, ib, za, zb;
        int ma, mb, ea, eb, u, odd;
        unpack_op(a, na, ia, za, ma, ea);
        unpack_op(b, nb, ib, zb, mb, eb);
        if (sq) begin
            nb = 1'b0; ib = 1'b0; zb = 1'b0; mb = 0;
            u      = ea - C_DIV_BIAS;
            odd    = u & 1;
            r.er   = 10'((u - odd) / 2 + C_DIV_BIAS);
            r.odd  = (odd != 0);
            r.sign = a[31];
        end else begin
            r.er   = 10'(ea - eb + C_DIV_BIAS);
            r.odd  = 1'b0;
            r.sign = a[31] ^ b[31];
        end
        r.ma      = 24'(ma);
        r.mb      = 24'(mb);
        r.flags   = {na, nb, ia, ib, za, zb};
        r.special = |r.flags;
        return r;
    endfunction

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input bit sq,
                            input logic [2:0] rm);
        @(negedge Clk_CI);
        Valid_SI = 1'b1; Div_start_SI = !sq; Sqrt_start_SI = sq;
        Operand_a_DI = a; Operand_b_DI = b; RM_SI = rm;
        @(negedge Clk_CI);
        Valid_SI = 1'b0; Operand_a_DI = $urandom; Operand_b_DI = $urandom; RM_SI = ~rm;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit sq, input int stall);
        expect_t ex;
        int lat;
        logic [2:0] rm;
        ex = model(a, b, sq);
        rm = 3'($urandom);
        drive_op(a, b, sq, rm);
        lat = 1;
        while (Valid_SO !== 1'b1 && lat < 8) begin
            @(negedge Clk_CI);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(EXP_LAT));
        check({tag, " ready_busy"}, 64'(Ready_SO), 64'd0);
        check({tag, " mant_a"}, 64'(Mant_a_DO), 64'(ex.ma));
        check({tag, " mant_b"}, 64'(Mant_b_DO), 64'(ex.mb));
        check({tag, " sign"}, 64'(Sign_res_DO), 64'(ex.sign));
        check({tag, " flags"}, 64'({NaN_a_SO, NaN_b_SO, Inf_a_SO, Inf_b_SO, Zero_a_SO, Zero_b_SO}),
              64'(ex.flags));
        check({tag, " op"}, 64'({Div_en_SO, Sqrt_en_SO}), 64'({!sq, sq}));
        check({tag, " rm"}, 64'(RM_SO), 64'(rm));
        if (!ex.special) begin
            check({tag, " exp_res"}, 64'(Exp_res_DO), 64'(ex.er));
            check({tag, " sqrt_odd"}, 64'(Sqrt_odd_SO), 64'(ex.odd));
        end
        for (int i = 0; i < stall; i++) begin
            Valid_SI = 1'b1; Div_start_SI = 1'b1; Sqrt_start_SI = 1'b0;
            Operand_a_DI = $urandom;
            @(negedge Clk_CI);
            check({tag, " stall valid"}, 64'(Valid_SO), 64'd1);
            check({tag, " stall ready"}, 64'(Ready_SO), 64'd0);
            check({tag, " stall mant_a"}, 64'(Mant_a_DO), 64'(ex.ma));
            check({tag, " stall sign"}, 64'(Sign_res_DO), 64'(ex.sign));
        end
        Ready_SI = 1'b1;
        @(negedge Clk_CI);
        Ready_SI = 1'b0; Valid_SI = 1'b0;
        check({tag, " release valid"}, 64'(Valid_SO), 64'd0);
        check({tag, " release ready"}, 64'(Ready_SO), 64'd1);
        if (stall > 0) begin
            @(negedge Clk_CI);
            check({tag, " handover ignored"}, 64'(Valid_SO), 64'd0);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [7:0]  ex;
        logic [22:0] f;
        f = 23'($urandom);
        case ($urandom_range(0, 9))
            0:       begin ex = 8'd0;   f = '0; end
            1:       begin ex = 8'd0;   if (f == 0) f = 23'd1; end
            2:       begin ex = 8'd255; f = '0; end
            3:       begin ex = 8'd255; if (f == 0) f = 23'd3; end
            default: ex = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), ex, f};
    endfunction

    initial begin
        Rst_RI = 1'b1; Valid_SI = 1'b0; Kill_SI = 1'b0; Div_start_SI = 1'b0; Sqrt_start_SI = 1'b0;
        Operand_a_DI = '0; Operand_b_DI = '0; RM_SI = '0; Ready_SI = 1'b0;
        repeat (3) @(negedge Clk_CI);
        Rst_RI = 1'b0;
        @(negedge Clk_CI);
        check("reset ready", 64'(Ready_SO), 64'd1);
        check("reset valid", 64'(Valid_SO), 64'd0);
        check("reset bundle", 64'({Mant_a_DO, Mant_b_DO, Exp_res_DO}), 64'd0);
        check("reset flags", 64'({Sqrt_odd_SO, Sign_res_DO, Div_en_SO, Sqrt_en_SO, NaN_a_SO, NaN_b_SO,
                                  Inf_a_SO, Inf_b_SO, Zero_a_SO, Zero_b_SO, RM_SO}), 64'd0);

        // 6.0 / 1.5 -> mantissas 0xC00000, Exp_res 129
        run_op("div6_1p5", 32'h40C00000, 32'h3FC00000, 1'b0, 0);
        run_op("div_denorm", 32'h00000001, 32'h3F800000, 1'b0, 0);
        run_op("div_denorm_b", 32'hC0000000, 32'h00400000, 1'b0, 0);
        // sqrt 8.0 -> odd, Exp_res 128; sqrt 4.0 -> even, Exp_res 128
        run_op("sqrt8", 32'h41000000, 32'h7FC00000, 1'b1, 0);
        run_op("sqrt4", 32'h40800000, 32'h00000000, 1'b1, 0);
        run_op("sqrt_denorm", 32'h80000003, 32'h3F800000, 1'b1, 0);
        run_op("nan_div", 32'h7FC00001, 32'h3F800000, 1'b0, 0);
        run_op("inf_inf", 32'hFF800000, 32'h7F800000, 1'b0, 0);
        run_op("zero_zero", 32'h80000000, 32'h00000000, 1'b0, 0);
        run_op("stall5", 32'h3F800001, 32'hBF7FFFFF, 1'b0, 5);

        // Both or neither start bit: request ignored
        @(negedge Clk_CI);
        Valid_SI = 1'b1; Div_start_SI = 1'b1; Sqrt_start_SI = 1'b1;
        repeat (2) @(negedge Clk_CI);
        Div_start_SI = 1'b0; Sqrt_start_SI = 1'b0;
        repeat (2) @(negedge Clk_CI);
        check("bad_start valid", 64'(Valid_SO), 64'd0);
        check("bad_start ready", 64'(Ready_SO), 64'd1);
        Valid_SI = 1'b0;

        // Kill in the cycle after accept
        drive_op(32'h40C00000, 32'h3FC00000, 1'b0, 3'd1);
        Kill_SI = 1'b1;
        @(negedge Clk_CI);
        Kill_SI = 1'b0;
        check("kill valid", 64'(Valid_SO), 64'd0);
        check("kill ready", 64'(Ready_SO), 64'd1);
        @(negedge Clk_CI);
        check("kill stays idle", 64'(Valid_SO), 64'd0);

        // Kill beats Valid_SI in IDLE
        Valid_SI = 1'b1; Div_start_SI = 1'b1; Sqrt_start_SI = 1'b0; Kill_SI = 1'b1;
        @(negedge Clk_CI);
        Valid_SI = 1'b0; Kill_SI = 1'b0;
        check("kill_idle ready", 64'(Ready_SO), 64'd1);
        repeat (2) @(negedge Clk_CI);
        check("kill_idle valid", 64'(Valid_SO), 64'd0);
        run_op("after_kill", 32'h41000000, 32'h40000000, 1'b0, 0);

        // Asynchronous reset while the bundle is waiting in DONE
        drive_op(32'h40C00000, 32'h3FC00000, 1'b0, 3'd2);
        for (int i = 0; i < 8 && Valid_SO !== 1'b1; i++) @(negedge Clk_CI);
        check("pre_rst valid", 64'(Valid_SO), 64'd1);
        Rst_RI = 1'b1;
        #1;
        check("rst valid", 64'(Valid_SO), 64'd0);
        check("rst ready", 64'(Ready_SO), 64'd1);
        @(negedge Clk_CI);
        Rst_RI = 1'b0;
        check("rst bundle", 64'({Mant_a_DO, Exp_res_DO, Div_en_SO}), 64'd0);
        run_op("after_rst", 32'h40800000, 32'h00000000, 1'b1, 0);

        for (int n = 0; n < 40; n++) begin
            run_op($sformatf("rand%0d", n), rand_operand(), rand_operand(),
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
